// File: rtl/fetch_aligner.sv
// fetch_aligner
//   Fetch-side stage directly upstream of decode in the RV32EC core.
//   Takes 32-bit word-aligned fetch words and re-slices them into whole
//   RVC (16-bit) or RV32 (32-bit) instructions, one per output handshake,
//   through a single registered output slot. Supports redirects to any
//   halfword, drops words that do not match the expected address, and
//   stitches 32-bit instructions that straddle a word boundary.
//
// Parameters
//   RESET_PC        PC of the first instruction after reset (bit 0 ignored)
// Ports
//   clk             clock
//   rst             synchronous reset, active-high
//   redirect_valid  flush and restart fetch alignment at redirect_pc
//   redirect_pc     new PC (bit 0 treated as 0)
//   in_valid        fetch word valid
//   in_ready        fetch word accepted this cycle
//   in_addr         word address of in_data (bits [1:0] == 0)
//   in_data         fetch word, little-endian
//   out_valid       output slot holds an instruction
//   out_ready       decode accepts the slot
//   out_instr       instruction; RVC is zero-extended {16'h0, half}
//   out_pc          PC of out_instr
//   out_compressed  1 = 16-bit RVC instruction
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_compressed
);

    // ALIGN: pc is word aligned, next word supplies the instruction at pc.
    // SKIP : pc sits on the upper half of a word; the lower half is discarded.
    // HOLD : the upper half of the last word (hold) is the halfword at pc.
    typedef enum logic [1:0] {
        ALIGN = 2'd0,
        SKIP  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_HW  = RESET_PC & ~32'h1;
    localparam state_t      RESET_STATE  = RESET_PC[1] ? SKIP : ALIGN;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [15:0] hold, hold_nx;
    logic        out_valid_nx;
    logic [31:0] out_instr_nx;
    logic [31:0] out_pc_nx;
    logic        out_compressed_nx;

    logic        slot_free;
    logic        hold_rvc;
    logic        lo_rvc;
    logic        needs_word;
    logic [31:0] exp_addr;
    logic        word_ok;

    assign slot_free = out_ready | ~out_valid;
    assign hold_rvc  = (hold[1:0] != 2'b11);
    assign lo_rvc    = (in_data[1:0] != 2'b11);

    // A held RVC halfword is emitted without consuming a word.
    assign needs_word = (state == ALIGN) || (state == SKIP) ||
                        ((state == HOLD) && !hold_rvc);
    assign in_ready   = slot_free & ~redirect_valid & needs_word;

    always_comb begin
        exp_addr = pc;
        case (state)
            ALIGN:   exp_addr = pc;
            SKIP:    exp_addr = {pc[31:2], 2'b00};
            HOLD:    exp_addr = pc + 32'd2;
            default: exp_addr = pc;
        endcase
    end

    // Mismatched accepted words fall through here with no effect (dropped).
    assign word_ok = in_valid & in_ready & (in_addr == exp_addr);

    always_comb begin
        state_nx          = state;
        pc_nx             = pc;
        hold_nx           = hold;
        out_valid_nx      = out_valid;
        out_instr_nx      = out_instr;
        out_pc_nx         = out_pc;
        out_compressed_nx = out_compressed;

        if (redirect_valid) begin
            state_nx     = redirect_pc[1] ? SKIP : ALIGN;
            pc_nx        = redirect_pc & ~32'h1;
            hold_nx      = '0;
            out_valid_nx = 1'b0;
        end else if (slot_free) begin
            out_valid_nx = 1'b0;
            case (state)
                ALIGN: begin
                    if (word_ok) begin
                        out_valid_nx = 1'b1;
                        out_pc_nx    = pc;
                        if (lo_rvc) begin
                            out_instr_nx      = {16'h0, in_data[15:0]};
                            out_compressed_nx = 1'b1;
                            hold_nx           = in_data[31:16];
                            pc_nx             = pc + 32'd2;
                            state_nx          = HOLD;
                        end else begin
                            out_instr_nx      = in_data;
                            out_compressed_nx = 1'b0;
                            pc_nx             = pc + 32'd4;
                        end
                    end
                end
                SKIP: begin
                    if (word_ok) begin
                        hold_nx  = in_data[31:16];
                        state_nx = HOLD;
                    end
                end
                HOLD: begin
                    if (hold_rvc) begin
                        out_valid_nx      = 1'b1;
                        out_pc_nx         = pc;
                        out_instr_nx      = {16'h0, hold};
                        out_compressed_nx = 1'b1;
                        pc_nx             = pc + 32'd2;
                        state_nx          = ALIGN;
                    end else if (word_ok) begin
                        out_valid_nx      = 1'b1;
                        out_pc_nx         = pc;
                        out_instr_nx      = {in_data[15:0], hold};
                        out_compressed_nx = 1'b0;
                        hold_nx           = in_data[31:16];
                        pc_nx             = pc + 32'd4;
                    end
                end
                default: begin
                    state_nx = ALIGN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RESET_STATE;
            pc             <= RESET_PC_HW;
            hold           <= '0;
            out_valid      <= 1'b0;
            out_instr      <= '0;
            out_pc         <= '0;
            out_compressed <= 1'b0;
        end else begin
            state          <= state_nx;
            pc             <= pc_nx;
            hold           <= hold_nx;
            out_valid      <= out_valid_nx;
            out_instr      <= out_instr_nx;
            out_pc         <= out_pc_nx;
            out_compressed <= out_compressed_nx;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
module tb_fetch_aligner;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_compressed;

    fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_compressed (out_compressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic comp);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.comp  = comp;
        sb.push_back(e);
    endtask

    // Scoreboard: every completed output handshake is compared to the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_instr", out_instr, e.instr);
                chk("out_pc", out_pc, e.pc);
                chk("out_compressed", {31'b0, out_compressed}, {31'b0, e.comp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("accept", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge clk);
        chk("redir_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        in_valid       = 1'b0;
        in_addr        = '0;
        in_data        = '0;
        out_ready      = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // T1: reset state, then a 32-bit word at 0, then next word expected at 4
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_comp", {31'b0, out_compressed}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        push(32'h00A0_0513, 32'h0, 1'b0);
        send(32'h0, 32'h00A0_0513);
        push(32'h0000_0013, 32'h4, 1'b0);
        send(32'h4, 32'h0000_0013);

        // T2: two RVC in one word; second emit needs no word
        redirect(32'h0);
        push(32'h0000_4501, 32'h0, 1'b1);
        push(32'h0000_4585, 32'h2, 1'b1);
        send(32'h0, 32'h4585_4501);
        @(negedge clk);
        chk("t2_in_ready_hold", {31'b0, in_ready}, 32'd0);
        tick();

        // T3: 32-bit instruction straddling words 0 and 4
        redirect(32'h0);
        push(32'h0000_4501, 32'h0, 1'b1);
        push(32'h00A0_0513, 32'h2, 1'b0);
        push(32'h0000_1234, 32'h6, 1'b1);
        send(32'h0, 32'h0513_4501);
        send(32'h4, 32'h1234_00A0);
        repeat (2) tick();

        // T4: redirect to a halfword, stale word dropped
        redirect(32'h102);
        send(32'h8, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t4_stale_no_out", {31'b0, out_valid}, 32'd0);
        tick();
        push(32'h0000_ABCD, 32'h102, 1'b1);
        send(32'h100, 32'hABCD_1111);
        push(32'h00B0_0593, 32'h104, 1'b0);
        send(32'h104, 32'h00B0_0593);
        tick();

        // T5: backpressure holds the slot stable
        out_ready = 1'b0;
        push(32'h0000_4501, 32'h108, 1'b1);
        push(32'h0000_4585, 32'h10A, 1'b1);
        send(32'h108, 32'h4585_4501);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_valid", {31'b0, out_valid}, 32'd1);
            chk("t5_instr", out_instr, 32'h0000_4501);
            chk("t5_pc", out_pc, 32'h108);
            chk("t5_in_ready", {31'b0, in_ready}, 32'd0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_next_valid", {31'b0, out_valid}, 32'd1);
        chk("t5_next_pc", out_pc, 32'h10A);
        tick();

        // T6: redirect with in_valid while slot is stalled
        out_ready = 1'b0;
        send(32'h10C, 32'h00A0_0513);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        in_valid       = 1'b1;
        in_addr        = 32'h110;
        in_data        = 32'h0000_0013;
        @(negedge clk);
        chk("t6_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        in_valid       = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        out_ready = 1'b1;

        // PC wrap from 0xFFFF_FFFE to 0
        redirect(32'hFFFF_FFFE);
        push(32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
        send(32'hFFFF_FFFC, 32'h0001_0513);
        push(32'h00A0_0513, 32'h0, 1'b0);
        send(32'h0, 32'h00A0_0513);
        repeat (2) tick();

        // Reset while in HOLD with a stalled slot
        out_ready = 1'b0;
        send(32'h4, 32'h0513_4501);
        @(negedge clk);
        chk("hold_slot_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_slot_instr", out_instr, 32'h0000_4501);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst2_out_instr", out_instr, 32'd0);
        chk("rst2_out_pc", out_pc, 32'd0);
        chk("rst2_out_comp", {31'b0, out_compressed}, 32'd0);
        chk("rst2_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        out_ready = 1'b1;
        push(32'h00A0_0513, 32'h0, 1'b0);
        send(32'h0, 32'h00A0_0513);

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
